// File: rtl/ram_wr_arbiter_pkg.sv
// Shared types and helpers for the RAM write-side arbiter.
// Holds the FSM state encoding and the width helpers used for the round-robin pointer and memory depth.
package ram_ctrl_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Index width for n requesters; never below 1 so a 2-entry pointer still has a bit.
   function automatic int clog2(input int n);
      int w;
      for (w = 1; (1 << w) < n; w++) begin
      end
      return w;
   endfunction

   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/ram_wr_arbiter_if.sv
// Requester handshake bus plus the two registered RAM write ports.
// The master side drives the requests; the slave side is the arbiter.
interface ram_wr_arbiter_if #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 3,
   parameter int NUM_REQ   = 4
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ*ADDRWIDTH-1:0] req_addr;
   logic [NUM_REQ*DATAWIDTH-1:0] req_data;
   logic                         en_w1_n;
   logic [ADDRWIDTH-1:0]         addr_w1;
   logic [DATAWIDTH-1:0]         data_w1;
   logic                         en_w2_n;
   logic [ADDRWIDTH-1:0]         addr_w2;
   logic [DATAWIDTH-1:0]         data_w2;
   logic                         init_done;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, en_w1_n, addr_w1, data_w1, en_w2_n, addr_w2, data_w2, init_done
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, en_w1_n, addr_w1, data_w1, en_w2_n, addr_w2, data_w2, init_done
   );
endinterface

// File: rtl/ram_wr_arbiter_rr_pick.sv
// Rotating-priority first-one finder: returns the first set bit of (vec & ~mask),
// searching upward from ptr and wrapping at N.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  vec_i,
   input  logic [N-1:0]  mask_i,
   input  logic [PW-1:0] ptr_i,
   output logic [PW-1:0] idx_o,
   output logic          found_o
);
   logic [N-1:0] cand;

   assign cand = vec_i & ~mask_i;

   // Walk from the farthest offset back to ptr so the nearest candidate is written last.
   always_comb begin
      logic [PW:0] jx;
      idx_o   = '0;
      found_o = 1'b0;
      jx      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         jx = {1'b0, ptr_i} + (PW + 1)'(k);
         if (jx >= (PW + 1)'(N)) begin
            jx = jx - (PW + 1)'(N);
         end
         if (cand[jx[PW-1:0]]) begin
            found_o = 1'b1;
            idx_o   = jx[PW-1:0];
         end
      end
   end
endmodule

// File: rtl/ram_wr_arbiter.sv
// Schedules up to two requester writes per clock onto the RAM's two write ports with
// round-robin priority, never issuing two writes to one address; optionally zero-fills first.
import ram_ctrl_pkg::*;

module ram_wr_arbiter #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 3,
   parameter int NUM_REQ   = 4,
   parameter int INIT_EN   = 1
) (
   input logic             clk,
   input logic             rst,
   ram_wr_arbiter_if.slave bus
);
   localparam int PW    = clog2(NUM_REQ);
   localparam int DEPTH = depth(ADDRWIDTH);
   localparam logic [ADDRWIDTH-1:0] INIT_LAST = ADDRWIDTH'(DEPTH / 2 - 1);

   state_t               state_q, state_d;
   logic [ADDRWIDTH-1:0] init_cnt_q, init_cnt_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic                 en_w1_n_q, en_w1_n_d, en_w2_n_q, en_w2_n_d;
   logic [ADDRWIDTH-1:0] addr_w1_q, addr_w1_d, addr_w2_q, addr_w2_d;
   logic [DATAWIDTH-1:0] data_w1_q, data_w1_d, data_w2_q, data_w2_d;
   logic                 init_done_q;

   logic [ADDRWIDTH-1:0] addr_a [NUM_REQ];
   logic [DATAWIDTH-1:0] data_a [NUM_REQ];
   logic [NUM_REQ-1:0]   mask2;
   logic [NUM_REQ-1:0]   ready;
   logic [PW-1:0]        g1, g2;
   logic                 f1, f2;

   // Second grant excludes the first winner and anything aimed at the same word.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign addr_a[gi] = bus.req_addr[gi*ADDRWIDTH +: ADDRWIDTH];
         assign data_a[gi] = bus.req_data[gi*DATAWIDTH +: DATAWIDTH];
         assign mask2[gi]  = (g1 == PW'(gi)) || (addr_a[gi] == addr_a[g1]);
         assign ready[gi]  = (state_q == RUN) &&
                             ((f1 && (g1 == PW'(gi))) || (f2 && (g2 == PW'(gi))));
      end
   endgenerate

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick1 (
      .vec_i(bus.req_valid), .mask_i('0), .ptr_i(rr_ptr_q), .idx_o(g1), .found_o(f1)
   );

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick2 (
      .vec_i(bus.req_valid), .mask_i(mask2), .ptr_i(rr_ptr_q), .idx_o(g2), .found_o(f2)
   );

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] g);
      return (g == PW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
   endfunction

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      en_w1_n_d  = 1'b1;
      addr_w1_d  = addr_w1_q;
      data_w1_d  = data_w1_q;
      en_w2_n_d  = 1'b1;
      addr_w2_d  = addr_w2_q;
      data_w2_d  = data_w2_q;
      case (state_q)
         INIT: begin
            en_w1_n_d  = 1'b0;
            en_w2_n_d  = 1'b0;
            addr_w1_d  = ADDRWIDTH'({init_cnt_q, 1'b0});
            addr_w2_d  = ADDRWIDTH'({init_cnt_q, 1'b1});
            data_w1_d  = '0;
            data_w2_d  = '0;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == INIT_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (f1) begin
               en_w1_n_d = 1'b0;
               addr_w1_d = addr_a[g1];
               data_w1_d = data_a[g1];
               rr_ptr_d  = wrap_inc(g1);
            end
            if (f2) begin
               en_w2_n_d = 1'b0;
               addr_w2_d = addr_a[g2];
               data_w2_d = data_a[g2];
               rr_ptr_d  = wrap_inc(g2);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= (INIT_EN != 0) ? INIT : RUN;
         init_cnt_q  <= '0;
         rr_ptr_q    <= '0;
         en_w1_n_q   <= 1'b1;
         addr_w1_q   <= '0;
         data_w1_q   <= '0;
         en_w2_n_q   <= 1'b1;
         addr_w2_q   <= '0;
         data_w2_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         en_w1_n_q   <= en_w1_n_d;
         addr_w1_q   <= addr_w1_d;
         data_w1_q   <= data_w1_d;
         en_w2_n_q   <= en_w2_n_d;
         addr_w2_q   <= addr_w2_d;
         data_w2_q   <= data_w2_d;
         init_done_q <= (state_q == RUN);
      end
   end

   assign bus.req_ready = ready;
   assign bus.en_w1_n   = en_w1_n_q;
   assign bus.addr_w1   = addr_w1_q;
   assign bus.data_w1   = data_w1_q;
   assign bus.en_w2_n   = en_w2_n_q;
   assign bus.addr_w2   = addr_w2_q;
   assign bus.data_w2   = data_w2_q;
   assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Bench for ram_wr_arbiter: a behavioural RAM sits behind the write ports, and a grant
// model feeds a scoreboard of expected port activity that is checked after each clock edge.
module tb_ram_wr_arbiter;
   logic clk;
   logic rst;

   ram_wr_arbiter_if #(.DATAWIDTH(8), .ADDRWIDTH(3), .NUM_REQ(4)) bus ();

   ram_wr_arbiter #(.DATAWIDTH(8), .ADDRWIDTH(3), .NUM_REQ(4), .INIT_EN(1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic       en1;
      logic [2:0] a1;
      logic [7:0] d1;
      logic       en2;
      logic [2:0] a2;
      logic [7:0] d2;
   } exp_t;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] mem     [8];
   logic [7:0] exp_mem [8];
   exp_t       sb [$];

   logic [3:0] pv;
   logic [2:0] pa [4];
   logic [7:0] pd [4];
   int         mptr;
   logic [2:0] last_a1, last_a2;
   logic [7:0] last_d1, last_d2;
   int         obs_grants [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural RAM behind the two write ports.
   always @(posedge clk) begin
      if (bus.en_w1_n == 1'b0) mem[bus.addr_w1] <= bus.data_w1;
      if (bus.en_w2_n == 1'b0) mem[bus.addr_w2] <= bus.data_w2;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   task automatic model_init();
      mptr    = 0;
      last_a1 = 3'd6;
      last_a2 = 3'd7;
      last_d1 = 8'h00;
      last_d2 = 8'h00;
      pv      = 4'b0000;
      for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < 4; i++) begin
         bus.req_valid[i]       = pv[i];
         bus.req_addr[i*3 +: 3] = pa[i];
         bus.req_data[i*8 +: 8] = pd[i];
      end
   endtask

   // One RUN cycle: predict grants, check ready, queue expected port state, then check it.
   task automatic step_run();
      int         g1, g2, j;
      logic [3:0] exp_rdy;
      exp_t       e, got;
      @(negedge clk);
      drive_reqs();
      #1;
      g1 = -1;
      g2 = -1;
      for (int k = 0; k < 4; k++) begin
         j = (mptr + k) % 4;
         if (pv[j]) begin
            if (g1 < 0) g1 = j;
            else if (g2 < 0 && pa[j] != pa[g1]) g2 = j;
         end
      end
      exp_rdy = 4'b0000;
      if (g1 >= 0) exp_rdy[g1] = 1'b1;
      if (g2 >= 0) exp_rdy[g2] = 1'b1;
      total++;
      if (bus.req_ready !== exp_rdy) begin
         bad++;
         $display("FAIL ready: got %b required %b", bus.req_ready, exp_rdy);
      end
      for (int i = 0; i < 4; i++) if (bus.req_ready[i] === 1'b1) obs_grants[i]++;
      e.en1 = (g1 < 0);
      if (g1 >= 0) begin
         last_a1 = pa[g1]; last_d1 = pd[g1]; exp_mem[pa[g1]] = pd[g1]; pv[g1] = 1'b0;
      end
      e.en2 = (g2 < 0);
      if (g2 >= 0) begin
         last_a2 = pa[g2]; last_d2 = pd[g2]; exp_mem[pa[g2]] = pd[g2]; pv[g2] = 1'b0;
      end
      e.a1 = last_a1; e.d1 = last_d1; e.a2 = last_a2; e.d2 = last_d2;
      if (g2 >= 0) mptr = (g2 + 1) % 4;
      else if (g1 >= 0) mptr = (g1 + 1) % 4;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = {bus.en_w1_n, bus.addr_w1, bus.data_w1, bus.en_w2_n, bus.addr_w2, bus.data_w2};
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL ports: got en1=%b a1=%0d d1=%h en2=%b a2=%0d d2=%h required en1=%b a1=%0d d1=%h en2=%b a2=%0d d2=%h",
                  got.en1, got.a1, got.d1, got.en2, got.a2, got.d2,
                  e.en1, e.a1, e.d1, e.en2, e.a2, e.d2);
      end
      $display("cycle: ready=%b en1=%b a1=%0d d1=%h en2=%b a2=%0d d2=%h",
               exp_rdy, got.en1, got.a1, got.d1, got.en2, got.a2, got.d2);
      if (got.en1 === 1'b0 && got.en2 === 1'b0) begin
         total++;
         if (got.a1 === got.a2) begin
            bad++;
            $display("FAIL collision: both ports enabled at addr %0d, required distinct", got.a1);
         end
      end
   endtask

   task automatic drain(input int maxc);
      int c = 0;
      while (pv != 4'b0000 && c < maxc) begin
         step_run();
         c++;
      end
      total++;
      if (pv != 4'b0000) begin
         bad++;
         $display("FAIL drain: pending=%b after %0d cycles, required 0000", pv, c);
      end
      step_run();
   endtask

   task automatic check_mem();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[i] !== exp_mem[i]) begin
            bad++;
            $display("FAIL mem[%0d]: got %h required %h", i, mem[i], exp_mem[i]);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      pv  = 4'b0000;
      drive_reqs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      model_init();
   endtask

   task automatic check_init_cycle(input string name, input int k);
      logic [24:0] got, want;
      got  = {bus.en_w1_n, bus.addr_w1, bus.data_w1, bus.en_w2_n, bus.addr_w2, bus.data_w2, bus.init_done};
      want = {1'b0, 3'(2 * k), 8'h00, 1'b0, 3'(2 * k + 1), 8'h00, 1'b0};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
      $display("%s: init write k=%0d a1=%0d a2=%0d", name, k, bus.addr_w1, bus.addr_w2);
   endtask

   task automatic check_reset_vals(input string name);
      logic [24:0] got;
      got = {bus.en_w1_n, bus.addr_w1, bus.data_w1, bus.en_w2_n, bus.addr_w2, bus.data_w2, bus.init_done};
      total++;
      if (got !== {1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, got, {1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0});
      end
   endtask

   task automatic check_run_entry(input string name);
      total++;
      if ({bus.init_done, bus.en_w1_n, bus.en_w2_n} !== 3'b111) begin
         bad++;
         $display("FAIL %s: got init_done/en1/en2=%b required 111",
                  name, {bus.init_done, bus.en_w1_n, bus.en_w2_n});
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      check_reset_vals("reset_vals");
      total++;
      if (bus.req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ready: got %b required 0000", bus.req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check_init_cycle("init", k);
         total++;
         if (bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL init_ready: got %b required 0000", bus.req_ready);
         end
      end
      @(posedge clk);
      #1;
      check_run_entry("init_done");
      model_init();
      check_mem();
   endtask

   task automatic test_single();
      pv = 4'b0001; pa[0] = 3'd3; pd[0] = 8'hA5;
      drain(4);
      total++;
      if (mem[3] !== 8'hA5) begin
         bad++;
         $display("FAIL single_mem3: got %h required a5", mem[3]);
      end
      check_mem();
   endtask

   task automatic test_four();
      do_reset();
      pv = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         pa[i] = 3'(i);
         pd[i] = 8'(8'h10 + i * 8'h11);
      end
      drain(4);
      check_mem();
   endtask

   task automatic test_collision();
      do_reset();
      pv = 4'b0011;
      pa[0] = 3'd5; pd[0] = 8'h11;
      pa[1] = 3'd5; pd[1] = 8'h22;
      drain(4);
      total++;
      if (mem[5] !== 8'h22) begin
         bad++;
         $display("FAIL collision_mem5: got %h required 22", mem[5]);
      end
      check_mem();
   endtask

   task automatic test_fairness();
      logic [2:0] prev_a1;
      for (int i = 0; i < 4; i++) begin
         obs_grants[i] = 0;
         pa[i] = 3'(i + 4);
         pd[i] = 8'($urandom_range(0, 255));
      end
      pv = 4'b1111;
      prev_a1 = 3'd0;
      for (int c = 0; c < 8; c++) begin
         step_run();
         if (c > 0) begin
            total++;
            if (bus.addr_w1 === prev_a1) begin
               bad++;
               $display("FAIL fair_g1_repeat: addr_w1=%0d in two consecutive cycles, required change", bus.addr_w1);
            end
         end
         prev_a1 = bus.addr_w1;
         if (c < 7) begin
            for (int i = 0; i < 4; i++) begin
               if (!pv[i]) begin
                  pv[i] = 1'b1;
                  pd[i] = 8'($urandom_range(0, 255));
               end
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs_grants[i] != 4) begin
            bad++;
            $display("FAIL fair_count[%0d]: got %0d grants required 4", i, obs_grants[i]);
         end
      end
      drain(4);
      check_mem();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst = 1'b1;
      pv  = 4'b0000;
      drive_reqs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("mid_init_reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_init_cycle("init_restart", 0);
      repeat (4) @(posedge clk);
      #1;
      check_run_entry("restart_done");
      model_init();
      @(negedge clk);
      bus.req_valid        = 4'b0001;
      bus.req_addr[0 +: 3] = 3'd2;
      bus.req_data[0 +: 8] = 8'h5A;
      #1;
      total++;
      if (bus.req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL accept_ready: got %b required 0001", bus.req_ready);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("run_reset_drop");
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 4'b0000;
      @(posedge clk);
      #1;
      check_init_cycle("run_reset_init", 0);
      repeat (4) @(posedge clk);
      #1;
      check_run_entry("run_reset_done");
      model_init();
      check_mem();
   endtask

   initial begin
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      for (int i = 0; i < 4; i++) begin
         pa[i] = 3'd0;
         pd[i] = 8'h00;
         obs_grants[i] = 0;
      end
      for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
      model_init();
      test_reset();
      test_single();
      test_four();
      test_collision();
      test_fairness();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
